// File: rtl/xsim_dma_burst_master.sv
// ---------------------------------------------------------------------------
// xsim_dma_burst_master
//
// Requester-side engine for the xsim simulated-DMA word port. One burst
// command (handle, byte address, word count) is expanded into a sequence of
// single-word read requests or write32 beats, the address stepping by STRIDE
// bytes per word. Read data is returned on a valid/ready stream; write data
// is taken from a valid/ready stream.
//
// Ports
//   CLK, RST                    clock (posedge) and synchronous active-high reset
//   i_cmd_*, o_cmd_ready        burst command handshake (write, handle, addr, len)
//   o_rd_valid/data/last        read word stream, i_rd_ready consumer backpressure
//   i_wr_valid/data, o_wr_ready write word stream
//   o_done, o_done_write        one-cycle completion pulse and burst direction
//   *_readrequest               single-word read request to the responder
//   *_readresponse              response word from the responder
//   *_write32                   single-word write to the responder
// ---------------------------------------------------------------------------
module xsim_dma_burst_master #(
    parameter int LEN_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_write,
    input  logic [31:0]      i_cmd_handle,
    input  logic [31:0]      i_cmd_addr,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_last,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [31:0]      i_wr_data,
    output logic             o_done,
    output logic             o_done_write,
    input  logic             i_rdy_readrequest,
    output logic             o_en_readrequest,
    output logic [31:0]      o_readrequest_handle,
    output logic [31:0]      o_readrequest_addr,
    input  logic             i_rdy_readresponse,
    output logic             o_en_readresponse,
    input  logic [31:0]      i_readresponse_data,
    output logic             o_en_write32,
    output logic [31:0]      o_write32_handle,
    output logic [31:0]      o_write32_addr,
    output logic [31:0]      o_write32_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0]      STRIDE_B = 32'(STRIDE);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [1:0]       r_state;
    logic             r_write;
    logic [31:0]      r_handle;
    logic [31:0]      r_cur_addr;
    logic [LEN_W-1:0] r_req_cnt;
    logic [LEN_W-1:0] r_resp_cnt;

    logic w_cmd_ready;
    logic w_rd_req_fire;
    logic w_rd_valid;
    logic w_rd_fire;
    logic w_wr_ready;
    logic w_wr_fire;
    logic w_done;

    // Handshake decode for the current state. Port enables are forced low
    // while RST is high so nothing reaches the responder during reset.
    always_comb begin
        w_cmd_ready   = 1'b0;
        w_rd_req_fire = 1'b0;
        w_rd_valid    = 1'b0;
        w_rd_fire     = 1'b0;
        w_wr_ready    = 1'b0;
        w_wr_fire     = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
            end
            ST_RD: begin
                // The responder only raises rdy_readrequest when its slot is
                // free or being drained this cycle, so one word per clock is
                // possible without ever overrunning it.
                w_rd_req_fire = i_rdy_readrequest && (r_req_cnt != LEN_ZERO) && !RST;
                w_rd_valid    = i_rdy_readresponse && !RST;
                w_rd_fire     = w_rd_valid && i_rd_ready;
            end
            ST_WR: begin
                w_wr_ready = !RST;
                w_wr_fire  = i_wr_valid && !RST;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_cmd_ready = 1'b0;
            end
        endcase
    end

    // Burst state machine, address stepping and word counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_handle   <= 32'd0;
            r_cur_addr <= 32'd0;
            r_req_cnt  <= LEN_ZERO;
            r_resp_cnt <= LEN_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_write    <= i_cmd_write;
                        r_handle   <= i_cmd_handle;
                        r_cur_addr <= i_cmd_addr;
                        r_req_cnt  <= i_cmd_len;
                        r_resp_cnt <= i_cmd_len;
                        if (i_cmd_len == LEN_ZERO) begin
                            r_state <= ST_DONE;
                        end else if (i_cmd_write) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (w_rd_req_fire) begin
                        r_cur_addr <= r_cur_addr + STRIDE_B;
                        r_req_cnt  <= r_req_cnt - LEN_ONE;
                    end
                    // Completion is tied to the last response, not the last
                    // request, so no word is left in the responder's slot.
                    if (w_rd_fire) begin
                        r_resp_cnt <= r_resp_cnt - LEN_ONE;
                        if (r_resp_cnt == LEN_ONE) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_WR: begin
                    if (w_wr_fire) begin
                        r_cur_addr <= r_cur_addr + STRIDE_B;
                        r_req_cnt  <= r_req_cnt - LEN_ONE;
                        if (r_req_cnt == LEN_ONE) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready          = w_cmd_ready;
    assign o_rd_valid           = w_rd_valid;
    assign o_rd_data            = w_rd_valid ? i_readresponse_data : 32'd0;
    assign o_rd_last            = w_rd_valid && (r_resp_cnt == LEN_ONE);
    assign o_en_readresponse    = w_rd_fire;
    assign o_en_readrequest     = w_rd_req_fire;
    assign o_readrequest_handle = (r_state == ST_RD) ? r_handle : 32'd0;
    assign o_readrequest_addr   = (r_state == ST_RD) ? r_cur_addr : 32'd0;
    assign o_wr_ready           = w_wr_ready;
    assign o_en_write32         = w_wr_fire;
    assign o_write32_handle     = (r_state == ST_WR) ? r_handle : 32'd0;
    assign o_write32_addr       = (r_state == ST_WR) ? r_cur_addr : 32'd0;
    assign o_write32_data       = (r_state == ST_WR) ? i_wr_data : 32'd0;
    assign o_done               = w_done;
    assign o_done_write         = w_done && r_write;

endmodule

// File: tb/tb_xsim_dma_burst_master.sv
// ---------------------------------------------------------------------------
// Testbench for xsim_dma_burst_master: a single-slot responder model, a
// scoreboard of expected requests/beats/completions filled when a command is
// issued, and a negedge monitor that pops and compares whenever the DUT acts.
// ---------------------------------------------------------------------------
module tb_xsim_dma_burst_master;

    typedef struct {
        logic [31:0] h;
        logic [31:0] a;
        logic [31:0] d;
    } wexp_t;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } rexp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_handle = 32'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = 32'd0;
    logic        done;
    logic        done_write;
    logic        rdy_readrequest;
    logic        en_readrequest;
    logic [31:0] readrequest_handle;
    logic [31:0] readrequest_addr;
    logic        rdy_readresponse;
    logic        en_readresponse;
    logic [31:0] readresponse_data;
    logic        en_write32;
    logic [31:0] write32_handle;
    logic [31:0] write32_addr;
    logic [31:0] write32_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_beats = 0;
    int first_req = -1;
    int last_req = -1;
    int first_beat = -1;
    int rd_mode = 0;
    int pat = 0;
    logic resp_gate = 1'b1;
    logic wr_gap = 1'b0;
    logic wr_fire_s = 1'b0;
    logic stalled_prev = 1'b0;
    logic [31:0] held_data = 32'd0;

    wexp_t       q_rdreq[$];
    rexp_t       q_rd[$];
    wexp_t       q_wr[$];
    logic        q_done[$];
    logic [31:0] wr_src[$];

    logic        m_full;
    logic [31:0] m_data;

    always #5 CLK = ~CLK;

    xsim_dma_burst_master #(.LEN_W(16), .STRIDE(4)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .i_cmd_valid          (cmd_valid),
        .o_cmd_ready          (cmd_ready),
        .i_cmd_write          (cmd_write),
        .i_cmd_handle         (cmd_handle),
        .i_cmd_addr           (cmd_addr),
        .i_cmd_len            (cmd_len),
        .o_rd_valid           (rd_valid),
        .i_rd_ready           (rd_ready),
        .o_rd_data            (rd_data),
        .o_rd_last            (rd_last),
        .i_wr_valid           (wr_valid),
        .o_wr_ready           (wr_ready),
        .i_wr_data            (wr_data),
        .o_done               (done),
        .o_done_write         (done_write),
        .i_rdy_readrequest    (rdy_readrequest),
        .o_en_readrequest     (en_readrequest),
        .o_readrequest_handle (readrequest_handle),
        .o_readrequest_addr   (readrequest_addr),
        .i_rdy_readresponse   (rdy_readresponse),
        .o_en_readresponse    (en_readresponse),
        .i_readresponse_data  (readresponse_data),
        .o_en_write32         (en_write32),
        .o_write32_handle     (write32_handle),
        .o_write32_addr       (write32_addr),
        .o_write32_data       (write32_data)
    );

    // Memory contents seen by reads: a fixed mix of handle and address.
    function automatic logic [31:0] mem_word(input logic [31:0] h, input logic [31:0] a);
        return h ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Single-slot responder: accepts a request when empty or when the held
    // word is being consumed in the same cycle.
    assign rdy_readrequest   = (!m_full || rd_ready) && resp_gate;
    assign rdy_readresponse  = m_full;
    assign readresponse_data = m_data;

    // Responder slot register, reset with the DUT.
    always @(posedge CLK) begin
        if (RST) begin
            m_full <= 1'b0;
            m_data <= 32'd0;
        end else if (en_readrequest) begin
            m_full <= 1'b1;
            m_data <= mem_word(readrequest_handle, readrequest_addr);
        end else if (en_readresponse) begin
            m_full <= 1'b0;
        end
    end

    // rd_ready / responder availability pattern.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rd_mode)
                0: begin rd_ready = 1'b1; resp_gate = 1'b1; end
                1: begin rd_ready = (pat == 0); pat = (pat + 1) % 3; resp_gate = 1'b1; end
                default: begin rd_ready = 1'($urandom % 2); resp_gate = ($urandom % 4) != 0; end
            endcase
        end
    end

    // Write-data source: offers the head of wr_src, with optional gaps.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (wr_fire_s && wr_src.size() > 0) wr_src.delete(0);
            if (wr_src.size() > 0) begin
                wr_valid = wr_gap ? 1'($urandom % 2) : 1'b1;
                wr_data  = wr_src[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
            end
        end
    end

    // Monitor: compares every DUT action against the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) begin
                chk("rst_en_readrequest", 32'(en_readrequest), 32'd0);
                chk("rst_en_readresponse", 32'(en_readresponse), 32'd0);
                chk("rst_en_write32", 32'(en_write32), 32'd0);
                stalled_prev = 1'b0;
                wr_fire_s = 1'b0;
            end else begin
                if (en_readrequest) begin
                    chk("rdreq_expected", 32'(q_rdreq.size() > 0), 32'd1);
                    if (q_rdreq.size() > 0) begin
                        wexp_t e;
                        e = q_rdreq.pop_front();
                        chk("rdreq_addr", readrequest_addr, e.a);
                        chk("rdreq_handle", readrequest_handle, e.h);
                    end
                    if (first_req < 0) first_req = cyc;
                    last_req = cyc;
                end
                if (stalled_prev) begin
                    chk("stall_valid_held", 32'(rd_valid), 32'd1);
                    chk("stall_data_held", rd_data, held_data);
                end
                if (rd_valid || en_readresponse)
                    chk("en_readresponse", 32'(en_readresponse), 32'(rd_valid && rd_ready));
                if (rd_valid && rd_ready) begin
                    chk("rd_beat_expected", 32'(q_rd.size() > 0), 32'd1);
                    if (q_rd.size() > 0) begin
                        rexp_t r;
                        r = q_rd.pop_front();
                        chk("rd_data", rd_data, r.d);
                        chk("rd_last", 32'(rd_last), 32'(r.last));
                    end
                    rd_beats++;
                    if (first_beat < 0) first_beat = cyc;
                end
                stalled_prev = rd_valid && !rd_ready;
                held_data = rd_data;
                if (en_write32 || wr_valid)
                    chk("en_write32", 32'(en_write32), 32'(wr_valid && wr_ready));
                if (en_write32) begin
                    chk("wr_beat_expected", 32'(q_wr.size() > 0), 32'd1);
                    if (q_wr.size() > 0) begin
                        wexp_t e;
                        e = q_wr.pop_front();
                        chk("wr_addr", write32_addr, e.a);
                        chk("wr_handle", write32_handle, e.h);
                        chk("wr_data", write32_data, e.d);
                    end
                end
                wr_fire_s = wr_valid && wr_ready;
                if (done) begin
                    chk("done_expected", 32'(q_done.size() > 0), 32'd1);
                    chk("done_after_rd", 32'(q_rd.size()), 32'd0);
                    chk("done_after_wr", 32'(q_wr.size()), 32'd0);
                    if (q_done.size() > 0) begin
                        logic dw;
                        dw = q_done.pop_front();
                        chk("done_write", 32'(done_write), 32'(dw));
                    end
                    chk("done_cmd_ready", 32'(cmd_ready), 32'd0);
                end
            end
        end
    end

    // Queue the expected behaviour of one burst, then offer its command.
    task automatic issue(input logic w, input logic [31:0] h, input logic [31:0] a,
                         input int len, input int mode, output logic acc);
        rd_mode = mode;
        wr_gap = (mode != 0);
        for (int i = 0; i < len; i++) begin
            wexp_t e;
            rexp_t r;
            logic [31:0] ea;
            ea = a + 32'(i * 4);
            e.h = h; e.a = ea; e.d = $urandom;
            if (w) begin
                q_wr.push_back(e);
                wr_src.push_back(e.d);
            end else begin
                q_rdreq.push_back(e);
                r.d = mem_word(h, ea);
                r.last = (i == len - 1);
                q_rd.push_back(r);
            end
        end
        q_done.push_back(w);
        first_req = -1;
        first_beat = -1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_handle = h; cmd_addr = a; cmd_len = 16'(len);
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 32'(acc), 32'd1);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_burst(input logic w, input logic [31:0] h, input logic [31:0] a,
                             input int len, input int mode);
        logic acc;
        int k;
        issue(w, h, a, len, mode, acc);
        if (len == 0) begin
            @(negedge CLK);
            chk("len0_done_next", 32'(done), 32'd1);
        end
        for (k = 0; k < 3000; k++) begin
            if (q_done.size() == 0) break;
            @(negedge CLK);
        end
        chk("burst_complete", 32'(q_done.size()), 32'd0);
        chk("rdreq_all_issued", 32'(q_rdreq.size()), 32'd0);
        if (!w && mode == 0 && len > 0) begin
            chk("req_back_to_back", 32'(last_req - first_req), 32'(len - 1));
            chk("first_beat_latency", 32'(first_beat - first_req), 32'd1);
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic acc;
        logic [31:0] ra;
        int b0;
        int k;

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);
        chk("idle_rdreq_addr", readrequest_addr, 32'd0);

        run_burst(1'b0, 32'hCAFE_0001, 32'h0000_0100, 4, 0);
        run_burst(1'b1, 32'hCAFE_0002, 32'h0000_0200, 3, 1);
        run_burst(1'b0, 32'hCAFE_0003, 32'h0000_0300, 3, 1);
        run_burst(1'b0, 32'hCAFE_0004, 32'h0000_0400, 0, 0);
        run_burst(1'b1, 32'hCAFE_0005, 32'h0000_0500, 0, 0);
        run_burst(1'b0, 32'hCAFE_0006, 32'hFFFF_FFFC, 2, 0);
        run_burst(1'b1, 32'hCAFE_0007, 32'hFFFF_FFF8, 4, 1);

        // Reset in the middle of an 8-word read.
        b0 = rd_beats;
        issue(1'b0, 32'hBEEF_0008, 32'h0000_0800, 8, 0, acc);
        for (k = 0; k < 200; k++) begin
            if (rd_beats >= b0 + 2) break;
            @(negedge CLK);
        end
        chk("mid_burst_two_beats", 32'(rd_beats - b0), 32'd2);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        q_rdreq.delete();
        q_rd.delete();
        q_done.delete();
        @(negedge CLK);
        chk("abort_en_readrequest", 32'(en_readrequest), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_no_done", 32'(done), 32'd0);
        run_burst(1'b0, 32'hBEEF_0009, 32'h0000_0900, 5, 0);

        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            ra[1:0] = 2'b00;
            if ($urandom % 4 == 0) ra = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            run_burst(1'($urandom % 2), $urandom, ra, $urandom_range(0, 10), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
